// File: rtl/ttt_game_controller.sv
// Tic-tac-toe game sequencer: owns the board, enforces turns, detects win/draw,
// and auto-plays the lowest empty cell when a player idles past TURN_TIMEOUT.
module ttt_game_controller #(
    parameter int TURN_TIMEOUT = 250_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [3:0]      cell_sel_i,
    input  logic            move_i,
    output logic [8:0][1:0] board_status_o,
    output logic [2:0]      current_screen_o,
    output logic            turn_o,
    output logic            move_err_o
);

    localparam int TW = (TURN_TIMEOUT > 0) ? $clog2(TURN_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLAST =
        TW'((TURN_TIMEOUT > 0) ? TURN_TIMEOUT - 1 : 0);
    localparam logic TEN = (TURN_TIMEOUT > 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_CHECK,
        S_END
    } state_t;

    state_t          r_state, w_state_n;
    logic [8:0][1:0] r_board, w_board_n;
    logic            r_turn,  w_turn_n;
    logic            r_err,   w_err_n;
    logic [TW-1:0]   r_timer, w_timer_n;
    logic [2:0]      r_result, w_result_n;

    logic            w_sel_ok;
    logic            w_full;
    logic            w_timeout;
    logic            w_place;
    logic [3:0]      w_place_idx;
    logic [3:0]      w_auto_idx;
    logic [1:0]      w_mark;
    logic [2:0]      w_screen;

    function automatic logic f_win(input logic [8:0][1:0] b,
                                   input logic [1:0] m);
        return (b[0] == m && b[1] == m && b[2] == m) ||
               (b[3] == m && b[4] == m && b[5] == m) ||
               (b[6] == m && b[7] == m && b[8] == m) ||
               (b[0] == m && b[3] == m && b[6] == m) ||
               (b[1] == m && b[4] == m && b[7] == m) ||
               (b[2] == m && b[5] == m && b[8] == m) ||
               (b[0] == m && b[4] == m && b[8] == m) ||
               (b[2] == m && b[4] == m && b[6] == m);
    endfunction

    always_comb begin
        w_state_n   = r_state;
        w_board_n   = r_board;
        w_turn_n    = r_turn;
        w_err_n     = 1'b0;
        w_timer_n   = r_timer;
        w_result_n  = r_result;
        w_place     = 1'b0;
        w_place_idx = cell_sel_i;
        w_mark      = r_turn ? 2'b10 : 2'b01;
        w_sel_ok    = 1'b0;
        w_full      = 1'b1;
        w_auto_idx  = 4'd0;
        w_timeout   = TEN && (r_timer == TLAST);

        for (int i = 8; i >= 0; i--) begin
            if (r_board[i] == 2'b00) begin
                w_auto_idx = 4'(i);
                w_full     = 1'b0;
                if (cell_sel_i == 4'(i)) w_sel_ok = 1'b1;
            end
        end

        if (start_i) begin
            w_board_n  = '0;
            w_turn_n   = 1'b0;
            w_timer_n  = '0;
            w_result_n = 3'd0;
            w_state_n  = S_PLAY;
        end else begin
            case (r_state)
                S_PLAY: begin
                    if (move_i && w_sel_ok) begin
                        w_place = 1'b1;
                    end else begin
                        w_err_n = move_i;
                        // A player's own move beats the timer in the same cycle
                        if (w_timeout) begin
                            w_place     = 1'b1;
                            w_place_idx = w_auto_idx;
                        end else if (!move_i && TEN) begin
                            w_timer_n = r_timer + TW'(1);
                        end
                    end
                    if (w_place) w_state_n = S_CHECK;
                end
                S_CHECK: begin
                    if (f_win(r_board, w_mark)) begin
                        w_result_n = r_turn ? 3'd3 : 3'd2;
                        w_state_n  = S_END;
                    end else if (w_full) begin
                        w_result_n = 3'd4;
                        w_state_n  = S_END;
                    end else begin
                        w_turn_n  = ~r_turn;
                        w_timer_n = '0;
                        w_state_n = S_PLAY;
                    end
                end
                default: ;
            endcase
        end

        for (int i = 0; i < 9; i++) begin
            if (w_place && w_place_idx == 4'(i)) w_board_n[i] = w_mark;
        end

        case (r_state)
            S_IDLE:  w_screen = 3'd0;
            S_END:   w_screen = r_result;
            default: w_screen = 3'd1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_board  <= '0;
            r_turn   <= 1'b0;
            r_err    <= 1'b0;
            r_timer  <= '0;
            r_result <= 3'd0;
        end else begin
            r_state  <= w_state_n;
            r_board  <= w_board_n;
            r_turn   <= w_turn_n;
            r_err    <= w_err_n;
            r_timer  <= w_timer_n;
            r_result <= w_result_n;
        end
    end

    assign board_status_o   = r_board;
    assign current_screen_o = w_screen;
    assign turn_o           = r_turn;
    assign move_err_o       = r_err;

endmodule

// File: tb/tb_ttt_game_controller.sv
// Scoreboard bench for ttt_game_controller: a rule-level game model predicts
// every cycle; a second instance with a short timeout exercises auto-play.
module tb_ttt_game_controller;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            a_start = 1'b0, a_move = 1'b0;
    logic [3:0]      a_sel = 4'd0;
    logic [8:0][1:0] a_board;
    logic [2:0]      a_scr;
    logic            a_turn, a_err;
    logic            b_start = 1'b0, b_move = 1'b0;
    logic [3:0]      b_sel = 4'd0;
    logic [8:0][1:0] b_board;
    logic [2:0]      b_scr;
    logic            b_turn, b_err;

    always #5 clk = ~clk;

    ttt_game_controller #(.TURN_TIMEOUT(0)) dut_a (
        .clk(clk), .rst(rst), .start_i(a_start), .cell_sel_i(a_sel),
        .move_i(a_move), .board_status_o(a_board),
        .current_screen_o(a_scr), .turn_o(a_turn), .move_err_o(a_err));

    ttt_game_controller #(.TURN_TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst), .start_i(b_start), .cell_sel_i(b_sel),
        .move_i(b_move), .board_status_o(b_board),
        .current_screen_o(b_scr), .turn_o(b_turn), .move_err_o(b_err));

    typedef struct packed {
        logic [17:0] board;
        logic [2:0]  scr;
        logic        turn;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Game model: mode 0 title, 1 awaiting move, 2 judging, 3 game over
    int   m_cell[9];
    int   m_mode = 0;
    int   m_scr = 0;
    int   m_turn = 0;
    int   m_err = 0;
    int   lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                          '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_cell[i]) m_cell[i] = 0;
        m_mode = 0; m_scr = 0; m_turn = 0; m_err = 0;
    endtask

    task automatic model_step(input bit st, input int sel, input bit mv);
        int me;
        bit won;
        m_err = 0;
        if (st) begin
            foreach (m_cell[i]) m_cell[i] = 0;
            m_turn = 0; m_mode = 1; m_scr = 1;
        end else if (m_mode == 1 && mv) begin
            if (sel < 9 && m_cell[sel] == 0) begin
                m_cell[sel] = m_turn + 1;
                m_mode = 2;
            end else begin
                m_err = 1;
            end
        end else if (m_mode == 2) begin
            me = m_turn + 1;
            won = 0;
            for (int l = 0; l < 8; l++)
                if (m_cell[lines[l][0]] == me && m_cell[lines[l][1]] == me &&
                    m_cell[lines[l][2]] == me) won = 1;
            if (won) begin
                m_scr = 2 + m_turn; m_mode = 3;
            end else if (!(0 inside {m_cell})) begin
                m_scr = 4; m_mode = 3;
            end else begin
                m_turn = 1 - m_turn; m_mode = 1;
            end
        end
    endtask

    task automatic cyc(input bit st, input int sel, input bit mv);
        exp_t e;
        @(negedge clk);
        #2;
        a_start = st; a_sel = 4'(sel); a_move = mv;
        model_step(st, sel, mv);
        for (int i = 0; i < 9; i++) e.board[2*i +: 2] = 2'(m_cell[i]);
        e.scr = 3'(m_scr);
        e.turn = 1'(m_turn);
        e.err = 1'(m_err);
        q.push_back(e);
    endtask

    task automatic play(input int sel);
        cyc(0, sel, 1);
        cyc(0, 0, 0);
    endtask

    task automatic drain();
        cyc(0, 0, 0);
        @(negedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("board", 32'(a_board), 32'(e.board));
            chk("screen", 32'(a_scr), 32'(e.scr));
            chk("turn", 32'(a_turn), 32'(e.turn));
            chk("move_err", 32'(a_err), 32'(e.err));
        end
    end

    initial begin
        model_reset();
        #3;
        chk("rst_board", 32'(a_board), 0);
        chk("rst_screen", 32'(a_scr), 0);
        chk("rst_turn", 32'(a_turn), 0);
        @(negedge clk);
        #2 rst = 1'b0;

        // Moves in title screen are ignored
        cyc(0, 0, 1); cyc(0, 0, 0);
        // Row win for X, later moves ignored
        cyc(1, 0, 0);
        play(0); play(3); play(1); play(4); play(2);
        play(5); play(6);
        // Rejected moves: occupied, out of range
        cyc(1, 0, 0);
        play(0); cyc(0, 0, 1); cyc(0, 9, 1); cyc(0, 15, 1); play(8);
        // Draw
        cyc(1, 0, 0);
        play(0); play(1); play(2); play(4); play(3);
        play(5); play(7); play(6); play(8); cyc(0, 0, 1);
        // Start and move together mid-game
        cyc(1, 0, 0);
        play(4); play(0); cyc(1, 5, 1); cyc(0, 0, 0);
        // Move presented during the judging cycle
        cyc(0, 2, 1); cyc(0, 3, 1); cyc(0, 3, 1);
        // Randomised play
        for (int n = 0; n < 600; n++)
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 15),
                $urandom_range(0, 1) == 1);
        // Asynchronous reset mid-play with three marks
        cyc(1, 0, 0);
        play(0); play(4); play(8);
        drain();
        rst = 1'b1;
        #1;
        chk("arst_board", 32'(a_board), 0);
        chk("arst_screen", 32'(a_scr), 0);
        chk("arst_turn", 32'(a_turn), 0);
        model_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        cyc(0, 1, 1); cyc(1, 0, 0); play(7);
        drain();

        // Timeout instance: idle play auto-places in lowest empty cell
        b_start = 1'b1;
        for (int k = 0; k <= 33; k++) begin
            @(negedge clk);
            if (k == 0) chk("to_start_scr", 32'(b_scr), 1);
            if (k == 15) chk("to_before", 32'(b_board), 0);
            if (k == 16) begin
                chk("to_cell0", 32'(b_board), 32'h1);
                chk("to_turn_hold", 32'(b_turn), 0);
            end
            if (k == 17) chk("to_turn", 32'(b_turn), 1);
            if (k == 32) chk("to_before2", 32'(b_board), 32'h1);
            if (k == 33) begin
                chk("to_cell1", 32'(b_board), 32'h9);
                chk("to_err", 32'(b_err), 0);
            end
            if (k == 0) #2 b_start = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
